// File: rtl/adder_result_fifo.sv
// adder_result_fifo: show-ahead result FIFO behind the 4-bit adder.
// Holds {Overflow, Sum} entries and keeps saturating statistics.
module adder_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     En,
    input  logic [WIDTH-1:0]         Sum,
    input  logic                     Overflow,
    input  logic                     Out_Ready,
    output logic                     Out_Valid,
    output logic [WIDTH-1:0]         Out_Sum,
    output logic                     Out_Ovf,
    output logic                     Full,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count,
    output logic [CNT_W-1:0]         Ovf_Cnt,
    output logic [CNT_W-1:0]         Drop_Cnt,
    output logic [WIDTH+CNT_W-1:0]   Total
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = WIDTH + CNT_W;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

    logic [WIDTH:0]    mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [TW-1:0]     total_q, total_d;
    logic [TW:0]       total_sum;
    occ_e              state_q, state_d;

    logic pop;
    logic push;
    logic drop;
    logic full;
    logic empty;

    assign full  = (state_q == OCC_FULL);
    assign empty = (state_q == OCC_EMPTY);

    assign pop  = !empty && Out_Ready;
    assign push = En && (!full || pop);
    assign drop = En && full && !pop;

    assign total_sum = {1'b0, total_q} + (TW+1)'(Sum);

    // Next-state for pointers, occupancy and statistics.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_cnt_d  = ovf_cnt_q;
        drop_cnt_d = drop_cnt_q;
        total_d    = total_q;
        state_d    = state_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (Overflow && !(&ovf_cnt_q)) begin
                ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
            end
            total_d = total_sum[TW] ? {TW{1'b1}} : total_sum[TW-1:0];
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (drop && !(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (count_d == CW'(0)) begin
            state_d = OCC_EMPTY;
        end else if (count_d == CW'(DEPTH)) begin
            state_d = OCC_FULL;
        end else begin
            state_d = OCC_PARTIAL;
        end
    end

    // Control and statistics registers; reset discards everything in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_cnt_q  <= '0;
            drop_cnt_q <= '0;
            total_q    <= '0;
            state_q    <= OCC_EMPTY;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_cnt_q  <= ovf_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            total_q    <= total_d;
            state_q    <= state_d;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge Clk) begin
        if (!Reset && push) begin
            mem_q[wr_ptr_q] <= {Overflow, Sum};
        end
    end

    assign Out_Valid = !empty;
    assign Out_Sum   = empty ? '0 : mem_q[rd_ptr_q][WIDTH-1:0];
    assign Out_Ovf   = empty ? 1'b0 : mem_q[rd_ptr_q][WIDTH];
    assign Full      = full;
    assign Empty     = empty;
    assign Count     = count_q;
    assign Ovf_Cnt   = ovf_cnt_q;
    assign Drop_Cnt  = drop_cnt_q;
    assign Total     = total_q;

endmodule
